// File: rtl/speicher_pkg.sv
// -----------------------------------------------------------------------------
// speicher_pkg
// Shared definitions for the memory access controller (speicher_steuerung):
//   - zustand_t  : controller state encoding (3 bits)
//   - besitzer_t : which requester owns the access in flight
//   - adr_breite : RAM word count -> address width
// -----------------------------------------------------------------------------
package speicher_pkg;

    typedef enum logic [2:0] {
        LEERLAUF         = 3'd0,
        LESEN_START      = 3'd1,
        LESEN_WARTEN     = 3'd2,
        SCHREIBEN_START  = 3'd3,
        SCHREIBEN_WARTEN = 3'd4,
        FERTIG           = 3'd5
    } zustand_t;

    typedef enum logic {
        BEFEHL = 1'b0,
        DATEN  = 1'b1
    } besitzer_t;

    // A single-word RAM still needs one address bit on the bus.
    function automatic int adr_breite(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/speicher_steuerung.sv
// -----------------------------------------------------------------------------
// speicher_steuerung
// Memory access controller in front of the processor's word RAM. Arbitrates
// between the instruction-fetch port and the load/store data port (data port
// has strict priority), issues single-cycle RAM read/write strobes, waits for
// the RAM acknowledge and returns the result with a one-cycle done pulse.
//
// Ports:
//   Clock, Reset                    rising-edge clock, async active-low reset
//   BefehlAnfrage/Adresse           fetch request (level) and word address
//   BefehlDaten/Bereit              fetched word, one-cycle done pulse
//   DatenAnfrage/Schreiben/Adresse  load/store request, 1 = store, address
//   DatenSchreibWert                store data
//   DatenLeseWert/Fertig            load result, one-cycle done pulse
//   RamLesenAn/RamSchreibenAn       RAM read/write strobes
//   RamAdresse/RamDatenRein         RAM address and write data
//   RamDatenRaus                    RAM read data
//   RamDatenBereit/Geschrieben      RAM read/write acknowledges
//   Zeitueberschreitung             sticky timeout flag (macro build only)
//
// Build option: define SPEICHER_TIMEOUT_EN to add a wait-cycle limit of
// TIMEOUT_ZYKLEN cycles and the Zeitueberschreitung output. Without it the
// controller waits indefinitely for the acknowledge.
// -----------------------------------------------------------------------------
module speicher_steuerung
    import speicher_pkg::*;
#(
    parameter int WORDSIZE       = 32,
    parameter int WORDS          = 32,
    parameter int TIMEOUT_ZYKLEN = 15,
    localparam int AW            = adr_breite(WORDS)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                BefehlAnfrage,
    input  logic [AW-1:0]       BefehlAdresse,
    output logic [WORDSIZE-1:0] BefehlDaten,
    output logic                BefehlBereit,
    input  logic                DatenAnfrage,
    input  logic                DatenSchreiben,
    input  logic [AW-1:0]       DatenAdresse,
    input  logic [WORDSIZE-1:0] DatenSchreibWert,
    output logic [WORDSIZE-1:0] DatenLeseWert,
    output logic                DatenFertig,
    output logic                RamLesenAn,
    output logic                RamSchreibenAn,
    output logic [AW-1:0]       RamAdresse,
    output logic [WORDSIZE-1:0] RamDatenRein,
    input  logic [WORDSIZE-1:0] RamDatenRaus,
    input  logic                RamDatenBereit,
    input  logic                RamDatenGeschrieben
`ifdef SPEICHER_TIMEOUT_EN
    ,
    output logic                Zeitueberschreitung
`endif
);

    zustand_t            zustand_q, zustand_d;
    besitzer_t           besitzer_q, besitzer_d;
    logic [AW-1:0]       adresse_q, adresse_d;
    logic [WORDSIZE-1:0] schreibwert_q, schreibwert_d;
    logic [WORDSIZE-1:0] befehl_daten_q, befehl_daten_d;
    logic [WORDSIZE-1:0] daten_lese_q, daten_lese_d;

`ifdef SPEICHER_TIMEOUT_EN
    localparam int ZW = $clog2(TIMEOUT_ZYKLEN + 1);
    logic [ZW-1:0] zaehler_q, zaehler_d;
    logic          zeitueber_q, zeitueber_d;
`endif

    always_comb begin
        zustand_d      = zustand_q;
        besitzer_d     = besitzer_q;
        adresse_d      = adresse_q;
        schreibwert_d  = schreibwert_q;
        befehl_daten_d = befehl_daten_q;
        daten_lese_d   = daten_lese_q;
`ifdef SPEICHER_TIMEOUT_EN
        // Counter only advances while waiting; every other state rearms it.
        zaehler_d      = '0;
        zeitueber_d    = zeitueber_q;
`endif

        unique case (zustand_q)
            LEERLAUF: begin
                // Data port wins any tie with the fetch port.
                if (DatenAnfrage) begin
                    besitzer_d    = DATEN;
                    adresse_d     = DatenAdresse;
                    schreibwert_d = DatenSchreibWert;
                    zustand_d     = DatenSchreiben ? SCHREIBEN_START : LESEN_START;
                end else if (BefehlAnfrage) begin
                    besitzer_d = BEFEHL;
                    adresse_d  = BefehlAdresse;
                    zustand_d  = LESEN_START;
                end
            end

            LESEN_START: zustand_d = LESEN_WARTEN;

            LESEN_WARTEN: begin
                if (RamDatenBereit) begin
                    if (besitzer_q == DATEN) daten_lese_d   = RamDatenRaus;
                    else                     befehl_daten_d = RamDatenRaus;
                    zustand_d = FERTIG;
                end
`ifdef SPEICHER_TIMEOUT_EN
                else if (zaehler_q == ZW'(TIMEOUT_ZYKLEN - 1)) begin
                    if (besitzer_q == DATEN) daten_lese_d   = '0;
                    else                     befehl_daten_d = '0;
                    zeitueber_d = 1'b1;
                    zustand_d   = FERTIG;
                end else begin
                    zaehler_d = zaehler_q + 1'b1;
                end
`endif
            end

            SCHREIBEN_START: zustand_d = SCHREIBEN_WARTEN;

            SCHREIBEN_WARTEN: begin
                if (RamDatenGeschrieben) begin
                    zustand_d = FERTIG;
                end
`ifdef SPEICHER_TIMEOUT_EN
                else if (zaehler_q == ZW'(TIMEOUT_ZYKLEN - 1)) begin
                    zeitueber_d = 1'b1;
                    zustand_d   = FERTIG;
                end else begin
                    zaehler_d = zaehler_q + 1'b1;
                end
`endif
            end

            // Requests are deliberately not sampled here so the requester
            // can drop or change its request before the next arbitration.
            FERTIG: zustand_d = LEERLAUF;

            default: zustand_d = LEERLAUF;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            zustand_q      <= LEERLAUF;
            besitzer_q     <= BEFEHL;
            adresse_q      <= '0;
            schreibwert_q  <= '0;
            befehl_daten_q <= '0;
            daten_lese_q   <= '0;
`ifdef SPEICHER_TIMEOUT_EN
            zaehler_q      <= '0;
            zeitueber_q    <= 1'b0;
`endif
        end else begin
            zustand_q      <= zustand_d;
            besitzer_q     <= besitzer_d;
            adresse_q      <= adresse_d;
            schreibwert_q  <= schreibwert_d;
            befehl_daten_q <= befehl_daten_d;
            daten_lese_q   <= daten_lese_d;
`ifdef SPEICHER_TIMEOUT_EN
            zaehler_q      <= zaehler_d;
            zeitueber_q    <= zeitueber_d;
`endif
        end
    end

    // Strobes and done pulses decode straight from the state register, so
    // each is high for exactly one cycle per access and reset kills them at once.
    assign RamLesenAn     = (zustand_q == LESEN_START);
    assign RamSchreibenAn = (zustand_q == SCHREIBEN_START);
    assign BefehlBereit   = (zustand_q == FERTIG) && (besitzer_q == BEFEHL);
    assign DatenFertig    = (zustand_q == FERTIG) && (besitzer_q == DATEN);
    assign RamAdresse     = adresse_q;
    assign RamDatenRein   = schreibwert_q;
    assign BefehlDaten    = befehl_daten_q;
    assign DatenLeseWert  = daten_lese_q;
`ifdef SPEICHER_TIMEOUT_EN
    assign Zeitueberschreitung = zeitueber_q;
`endif

endmodule

// File: tb/tb_speicher_steuerung.sv
module tb_speicher_steuerung;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          BefehlAnfrage;
    logic [AW-1:0] BefehlAdresse;
    logic [W-1:0]  BefehlDaten;
    logic          BefehlBereit;
    logic          DatenAnfrage;
    logic          DatenSchreiben;
    logic [AW-1:0] DatenAdresse;
    logic [W-1:0]  DatenSchreibWert;
    logic [W-1:0]  DatenLeseWert;
    logic          DatenFertig;
    logic          RamLesenAn;
    logic          RamSchreibenAn;
    logic [AW-1:0] RamAdresse;
    logic [W-1:0]  RamDatenRein;
    logic [W-1:0]  RamDatenRaus;
    logic          RamDatenBereit;
    logic          RamDatenGeschrieben;
`ifdef SPEICHER_TIMEOUT_EN
    logic          Zeitueberschreitung;
`endif

    speicher_steuerung dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .BefehlAnfrage      (BefehlAnfrage),
        .BefehlAdresse      (BefehlAdresse),
        .BefehlDaten        (BefehlDaten),
        .BefehlBereit       (BefehlBereit),
        .DatenAnfrage       (DatenAnfrage),
        .DatenSchreiben     (DatenSchreiben),
        .DatenAdresse       (DatenAdresse),
        .DatenSchreibWert   (DatenSchreibWert),
        .DatenLeseWert      (DatenLeseWert),
        .DatenFertig        (DatenFertig),
        .RamLesenAn         (RamLesenAn),
        .RamSchreibenAn     (RamSchreibenAn),
        .RamAdresse         (RamAdresse),
        .RamDatenRein       (RamDatenRein),
        .RamDatenRaus       (RamDatenRaus),
        .RamDatenBereit     (RamDatenBereit),
        .RamDatenGeschrieben(RamDatenGeschrieben)
`ifdef SPEICHER_TIMEOUT_EN
        ,
        .Zeitueberschreitung(Zeitueberschreitung)
`endif
    );

    always #5 Clock = ~Clock;

    // RAM model contents and an independent reference copy of what the
    // memory should hold according to the requests issued so far.
    logic [W-1:0] mem     [N];
    logic [W-1:0] ref_mem [N];

    int vectors     = 0;
    int miscompares = 0;
    int cycles      = 0;
    int rd_cnt      = 0;
    int wr_cnt      = 0;

    bit            rd_act, wr_act, ram_mute, stale_ack;
    int            rd_wait, wr_wait, ram_extra;
    logic [AW-1:0] rd_adr, wr_adr;
    logic [W-1:0]  wr_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: capture strobes, advance to just after the edge, then play
    // the RAM's acknowledge (ram_extra additional wait cycles).
    task automatic cyc();
        if (RamLesenAn && !ram_mute) begin
            rd_act = 1; rd_wait = ram_extra; rd_adr = RamAdresse;
        end
        if (RamSchreibenAn && !ram_mute) begin
            wr_act = 1; wr_wait = ram_extra; wr_adr = RamAdresse; wr_dat = RamDatenRein;
        end
        @(posedge Clock);
        #1;
        cycles++;
        RamDatenBereit      = stale_ack;
        RamDatenGeschrieben = 1'b0;
        RamDatenRaus        = $urandom;
        if (rd_act) begin
            if (rd_wait == 0) begin
                RamDatenBereit = 1'b1; RamDatenRaus = mem[rd_adr]; rd_act = 0;
            end else rd_wait--;
        end
        if (wr_act) begin
            if (wr_wait == 0) begin
                RamDatenGeschrieben = 1'b1; mem[wr_adr] = wr_dat; wr_act = 0;
            end else wr_wait--;
        end
        if (RamLesenAn) rd_cnt++;
        if (RamSchreibenAn) wr_cnt++;
        chk("strobe_excl", {31'b0, RamLesenAn & RamSchreibenAn}, 32'd0);
    endtask

    // One complete access from a single requester, checked against the
    // reference memory: 3 cycles + RAM extra wait, one strobe of the right kind.
    task automatic access(input bit is_data, input bit wr, input logic [AW-1:0] a,
                          input logic [W-1:0] wd, input int extra, input string tag);
        int n, rd0, wr0;
        bit done;
        logic [W-1:0] exp, prev_lese;
        ram_extra = extra; rd0 = rd_cnt; wr0 = wr_cnt; prev_lese = DatenLeseWert;
        if (is_data) begin
            DatenAnfrage = 1; DatenSchreiben = wr; DatenAdresse = a; DatenSchreibWert = wd;
        end else begin
            BefehlAnfrage = 1; BefehlAdresse = a;
        end
        if (wr) ref_mem[a] = wd;
        exp = wr ? prev_lese : ref_mem[a];
        n = 0; done = 0;
        while (!done && n < 40) begin
            cyc(); n++;
            done = is_data ? DatenFertig : BefehlBereit;
        end
        chk({tag, "_latency"}, n, 3 + extra);
        chk({tag, "_data"}, is_data ? DatenLeseWert : BefehlDaten, exp);
        chk({tag, "_other_done"}, {31'b0, is_data ? BefehlBereit : DatenFertig}, 32'd0);
        chk({tag, "_rd_strobes"}, rd_cnt - rd0, wr ? 0 : 1);
        chk({tag, "_wr_strobes"}, wr_cnt - wr0, wr ? 1 : 0);
        DatenAnfrage = 0; BefehlAnfrage = 0;
        cyc();
        chk({tag, "_done_once"}, {30'b0, BefehlBereit, DatenFertig}, 32'd0);
        chk({tag, "_hold"}, is_data ? DatenLeseWert : BefehlDaten, exp);
        if (wr) chk({tag, "_ram_word"}, mem[a], wd);
    endtask

    initial begin
        int n, t_d, t_prev;
        Reset = 0; BefehlAnfrage = 0; BefehlAdresse = '0; DatenAnfrage = 0;
        DatenSchreiben = 0; DatenAdresse = '0; DatenSchreibWert = '0;
        RamDatenRaus = '0; RamDatenBereit = 0; RamDatenGeschrieben = 0;
        rd_act = 0; wr_act = 0; ram_mute = 0; stale_ack = 0; ram_extra = 0;
        rd_wait = 0; wr_wait = 0; rd_adr = '0; wr_adr = '0; wr_dat = '0;
        for (int i = 0; i < N; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;

        // Reset state
        DatenAnfrage = 1; BefehlAnfrage = 1;
        repeat (3) cyc();
        chk("rst_lesen", {31'b0, RamLesenAn}, 0);
        chk("rst_schreiben", {31'b0, RamSchreibenAn}, 0);
        chk("rst_adresse", {27'b0, RamAdresse}, 0);
        chk("rst_datenrein", RamDatenRein, 0);
        chk("rst_befehldaten", BefehlDaten, 0);
        chk("rst_leseewert", DatenLeseWert, 0);
        chk("rst_done", {30'b0, BefehlBereit, DatenFertig}, 0);
`ifdef SPEICHER_TIMEOUT_EN
        chk("rst_timeout", {31'b0, Zeitueberschreitung}, 0);
`endif
        DatenAnfrage = 0; BefehlAnfrage = 0;
        Reset = 1;
        cyc();

        // Fetch read, store then load
        access(0, 0, 5, '0, 0, "fetch5");
        access(1, 1, 9, 32'h12345678, 0, "store9");
        access(1, 0, 9, '0, 0, "load9");

        // Contention: data first, fetch granted after FERTIG
        ram_extra = 0;
        DatenAnfrage = 1; DatenSchreiben = 0; DatenAdresse = 3;
        BefehlAnfrage = 1; BefehlAdresse = 4;
        n = 0;
        while (!DatenFertig && n < 40) begin cyc(); n++; end
        chk("cont_data_latency", n, 3);
        chk("cont_data_val", DatenLeseWert, ref_mem[3]);
        chk("cont_fetch_waits", {31'b0, BefehlBereit}, 0);
        t_d = cycles; DatenAnfrage = 0; n = 0;
        while (!BefehlBereit && n < 40) begin cyc(); n++; end
        chk("cont_fetch_gap", cycles - t_d, 4);
        chk("cont_fetch_val", BefehlDaten, ref_mem[4]);
        BefehlAnfrage = 0;
        cyc();

        // Held fetch request, address stepped in each done cycle
        BefehlAnfrage = 1; BefehlAdresse = 0; t_prev = cycles;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!BefehlBereit && n < 40) begin cyc(); n++; end
            chk("held_spacing", cycles - t_prev, (k == 0) ? 3 : 4);
            chk("held_word", BefehlDaten, ref_mem[k]);
            t_prev = cycles;
            if (k < 2) BefehlAdresse = AW'(k + 1);
            else BefehlAnfrage = 0;
            cyc();
        end

        // Reset during LESEN_WARTEN with a stale acknowledge
        BefehlAnfrage = 1; BefehlAdresse = 7;
        cyc(); cyc();
        Reset = 0; #1;
        chk("rstmid_lesen", {31'b0, RamLesenAn}, 0);
        chk("rstmid_adresse", {27'b0, RamAdresse}, 0);
        chk("rstmid_daten", BefehlDaten, 0);
        chk("rstmid_lese", DatenLeseWert, 0);
        chk("rstmid_done", {30'b0, BefehlBereit, DatenFertig}, 0);
        BefehlAnfrage = 0; ram_mute = 1; stale_ack = 1; rd_act = 0;
        RamDatenBereit = 1;
        cyc();
        Reset = 1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            n += BefehlBereit + DatenFertig + RamLesenAn + RamSchreibenAn;
        end
        chk("rstmid_no_done", n, 0);
        stale_ack = 0; ram_mute = 0;
        cyc();

        // Randomized traffic against the reference memory
        for (int i = 0; i < 30; i++) begin
            bit d, w;
            d = 1'($urandom_range(0, 1));
            w = d ? 1'($urandom_range(0, 1)) : 1'b0;
            access(d, w, AW'($urandom_range(0, N - 1)), $urandom,
                   $urandom_range(0, 3), "rand");
        end

`ifdef SPEICHER_TIMEOUT_EN
        // Timeout: RAM never acknowledges
        ram_mute = 1; ram_extra = 0;
        BefehlAnfrage = 1; BefehlAdresse = 5;
        n = 0;
        while (!BefehlBereit && n < 60) begin cyc(); n++; end
        chk("to_latency", n, 17);
        chk("to_data", BefehlDaten, 0);
        chk("to_flag", {31'b0, Zeitueberschreitung}, 1);
        BefehlAnfrage = 0;
        repeat (3) cyc();
        chk("to_sticky", {31'b0, Zeitueberschreitung}, 1);
        ram_mute = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/speicher_steuerung.md
Name: speicher_steuerung

Overview:
- Memory access controller directly upstream of the processor's word RAM.
- Arbitrates between an instruction-fetch port and a load/store data port, then drives the RAM's read/write strobes as single-cycle pulses.
- Waits for the RAM's ready/written acknowledge and returns the result to the requester with a one-cycle done pulse.

Parameters:
- WORDSIZE, 32, data word width in bits (matches the RAM).
- WORDS, 32, number of RAM words; address width is $clog2(WORDS).
- TIMEOUT_ZYKLEN, 15, wait-cycle limit; used only when SPEICHER_TIMEOUT_EN is defined.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- BefehlAnfrage  in  1  fetch request (level; held until BefehlBereit).
- BefehlAdresse  in  AW  fetch word address.
- BefehlDaten  out  WORDSIZE  fetched word, valid while BefehlBereit=1.
- BefehlBereit  out  1  fetch done, one-cycle pulse.
- DatenAnfrage  in  1  load/store request (level; held until DatenFertig).
- DatenSchreiben  in  1  1 = store, 0 = load.
- DatenAdresse  in  AW  load/store word address.
- DatenSchreibWert  in  WORDSIZE  store data.
- DatenLeseWert  out  WORDSIZE  load result, valid while DatenFertig=1.
- DatenFertig  out  1  load/store done, one-cycle pulse.
- RamLesenAn  out  1  RAM read strobe.
- RamSchreibenAn  out  1  RAM write strobe.
- RamAdresse  out  AW  RAM address.
- RamDatenRein  out  WORDSIZE  RAM write data.
- RamDatenRaus  in  WORDSIZE  RAM read data.
- RamDatenBereit  in  1  RAM read acknowledge (one cycle after the strobe).
- RamDatenGeschrieben  in  1  RAM write acknowledge.

Behaviour:
- Reset (Reset=0, asynchronous): state LEERLAUF; all outputs 0, including the data and address buses.
- States:
  - LEERLAUF: arbitrate requests.
  - LESEN_START, LESEN_WARTEN: read access.
  - SCHREIBEN_START, SCHREIBEN_WARTEN: write access.
  - FERTIG: done cycle.
- LEERLAUF:
  - Data port has strict priority over fetch.
  - DatenAnfrage=1 → latch address, write data and an internal "owner = data" flag; go to SCHREIBEN_START if DatenSchreiben=1, else LESEN_START.
  - Otherwise, if BefehlAnfrage=1 → latch address, owner = fetch, go to LESEN_START.
  - RamDatenBereit and RamDatenGeschrieben are ignored in this state.
- LESEN_START: RamLesenAn=1 for exactly this cycle, with RamAdresse = latched address → LESEN_WARTEN.
- LESEN_WARTEN:
  - RamLesenAn=0.
  - On RamDatenBereit=1: register RamDatenRaus into the owner's data output, pulse the owner's done for the next cycle → FERTIG.
- SCHREIBEN_START: RamSchreibenAn=1 for one cycle; RamDatenRein and RamAdresse = latched values → SCHREIBEN_WARTEN.
- SCHREIBEN_WARTEN: on RamDatenGeschrieben=1, pulse DatenFertig → FERTIG. DatenLeseWert is unchanged.
- FERTIG:
  - Done output is high for this cycle only.
  - Requests are not sampled; the requester drops or changes its request here.
  - → LEERLAUF.
- Latency: with a request sampled at edge t0, the strobe is high during (t0, t1), the RAM acknowledges during (t1, t2), and done is high during (t2, t3). Three cycles request-to-done; the next grant is possible at t3.
- Strobes are never asserted in the same cycle, and never more than once per access.
- RamAdresse and RamDatenRein hold the latched values from grant until the next grant.
- Data outputs hold their last value after the done pulse.
- A request that drops before grant is never served. Address or data changes after grant are ignored.
- Reset mid-access aborts the access: no done pulse, and any late RAM acknowledge is ignored.

Optional Feature:
- Macro SPEICHER_TIMEOUT_EN.
- Defined:
  - Adds output Zeitueberschreitung (1 bit, sticky; cleared only by reset).
  - A wait counter runs in LESEN_WARTEN and SCHREIBEN_WARTEN.
  - After TIMEOUT_ZYKLEN cycles without acknowledge: set Zeitueberschreitung, drive the owner's data output to 0 for reads, pulse the owner's done, → FERTIG.
- Undefined: no port, no counter; the controller waits indefinitely.

Decomposition:
- speicher_pkg: state encoding constants (LEERLAUF … FERTIG, 3 bits), owner encoding (BEFEHL=0, DATEN=1), address-width helper.
- No sub-module; the priority arbiter is a few lines inside the LEERLAUF decode.

Test Plan:
- Fetch read: RAM preloaded with word 5 = 0xDEADBEEF; BefehlAnfrage=1, BefehlAdresse=5 → RamLesenAn one cycle, BefehlBereit pulse 3 cycles later with BefehlDaten=0xDEADBEEF.
- Store then load: store 0x12345678 to address 9 → DatenFertig pulse; then load address 9 → DatenLeseWert=0x12345678, RamSchreibenAn pulsed exactly once.
- Contention: DatenAnfrage (load, address 3) and BefehlAnfrage (address 4) raised in the same cycle → data served first; fetch granted at the cycle after FERTIG; BefehlBereit follows DatenFertig by 4 cycles.
- Held request: BefehlAnfrage kept high across 3 accesses, address 0,1,2 changed in each FERTIG cycle → three BefehlBereit pulses spaced 4 cycles apart, with correct words.
- Reset mid-access: Reset=0 during LESEN_WARTEN → all outputs 0 immediately; no BefehlBereit after release, despite a stale RamDatenBereit.
- Timeout (SPEICHER_TIMEOUT_EN, TIMEOUT_ZYKLEN=15): RamDatenBereit tied 0 → done pulse after 15 wait cycles, data 0, Zeitueberschreitung=1 and held.
